// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the sync_fifo slice.
// Read-mode selectors and the occupancy-counter width function.
package fifo_pkg;

  localparam int MODE_REGISTERED = 0;
  localparam int MODE_SHOWAHEAD  = 1;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping index for an arbitrary-depth ring buffer.
// Wraps by explicit compare so DEPTH need not be a power of two.
module fifo_ptr #(
  parameter int DEPTH = 8,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  // advance on inc, wrap after the last slot; clr has priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, any depth >= 2, registered or show-ahead read.
// Status flags decode straight from the registered occupancy count.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int SHOWAHEAD  = MODE_REGISTERED,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          wren,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic                          rden,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic                          o_valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = $clog2(DEPTH);

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

  if (DEPTH < 2 || AF_LEVEL > DEPTH || AE_LEVEL > DEPTH) begin : g_bad_param
    $error("sync_fifo: illegal DEPTH/AF_LEVEL/AE_LEVEL");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic                  rd_ok;
  logic                  wr_ok;

  assign full         = (count == FULL_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // a full FIFO still takes a write when a read frees a slot this cycle
  assign rd_ok = rden & ~empty & ~clr;
  assign wr_ok = wren & (~full | rd_ok) & ~clr;

  fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_head (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (rd_ok),
    .ptr (head)
  );

  fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_tail (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (wr_ok),
    .ptr (tail)
  );

  // storage is never reset or flushed, only overwritten
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[tail] <= i_data;
    end
  end

  // occupancy and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok && !rd_ok) begin
        count <= count + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count <= count - 1'b1;
      end
      overflow  <= overflow | (wren & ~wr_ok);
      underflow <= underflow | (rden & empty);
    end
  end

  if (SHOWAHEAD == MODE_SHOWAHEAD) begin : g_showahead
    // head word is presented whenever the FIFO holds data
    always_comb begin
      o_data  = empty ? '0 : mem[head];
      o_valid = !empty;
    end
  end else begin : g_registered
    // load head word on an accepted read, valid for one cycle
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        o_data  <= '0;
        o_valid <= 1'b0;
      end else if (clr) begin
        o_valid <= 1'b0;
      end else begin
        o_valid <= rd_ok;
        if (rd_ok) begin
          o_data <= mem[head];
        end
      end
    end
  end

endmodule
